load_width_mux: RTL and testbench
=================================

// Module: load_width_mux
// PURPOSE
//  Load-result selector for the data memory read path. Picks one of five
//  pre-extended 32-bit read values using the 3-bit access-type code: signed
//  byte, signed half, word, unsigned byte or unsigned half. The selected value
//  drives the memory RD output toward the register-file write-back.
//  Also registers a diagnostic flag that marks reserved access codes.
// PARAMETERS
//  DW  32  data width of every candidate input and of out
// PORTS
//  CLK       in   1    system clock; sel_err updates on the rising edge
//  RST_N     in   1    asynchronous active-low reset
//  selector  in   3    access type: 0=SB 1=SH 2=W 4=UB 5=UH; 3,6,7 reserved
//  S8        in   DW   sign-extended byte read value
//  S16       in   DW   sign-extended halfword read value
//  W         in   DW   full word read value
//  U8        in   DW   zero-extended byte read value
//  U16       in   DW   zero-extended halfword read value
//  out       out  DW   selected load result
//  sel_err   out  1    registered flag: previous cycle's selector was reserved
// BEHAVIOUR
//  Interface: one clock, CLK. Reset RST_N is asynchronous and active-low.
//  out is purely combinational, with zero-cycle latency from selector and
//   every data input:
//   selector 3'd0 -> S8, 3'd1 -> S16, 3'd2 -> W, 3'd4 -> U8, 3'd5 -> U16.
//   Reserved codes 3'd3, 3'd6 and 3'd7 -> out = 0 (all bits zero).
//   No X-propagation from unselected inputs.
//   Full case, no inferred latches.
//  out is not reset: it follows its inputs regardless of RST_N.
//  The block performs no extension itself. Inputs arrive already extended
//   and are passed through bit-exact.
//  sel_err: on each rising CLK edge, sel_err <= (selector is 3, 6 or 7).
//   The flag is not sticky. It is high for exactly the cycle after each
//   edge that sampled a reserved code.
//  Reset: RST_N low forces sel_err = 0 immediately, without waiting for
//   CLK, and holds it at 0 while low. The first edge after RST_N rises
//   samples normally.
//  Reset asserted mid-operation: sel_err clears at once; out is unaffected.
//  Selector changes between edges: out follows combinationally. sel_err
//   reflects only the value sampled at the edge.
// TESTING
//  selector=0, S8=32'hFFFF_FF80, other inputs=32'hDEAD_BEEF
//   -> out=32'hFFFF_FF80; sel_err=0 after the edge.
//  Sweep selector 1/2/4/5, with S16=32'hFFFF_8001, W=32'h1234_5678,
//   U8=32'h0000_0080, U16=32'h0000_8001
//   -> out equals the matching input each step; sel_err stays 0.
//  selector=3, then 6, then 7, with all inputs=32'hFFFF_FFFF
//   -> out=0 in each case; sel_err=1 after each edge.
//   Then selector=2 -> sel_err=0 after the next edge.
//  selector=7 clocked (sel_err=1), then RST_N pulled low between edges
//   -> sel_err=0 immediately; out still 0.
//   Release RST_N with selector=2 -> sel_err stays 0.
//  With selector=2 held constant, toggle W across random values between
//   edges -> out tracks W with no clock dependence.

Source files
------------

// File: rtl/load_width_mux.sv
// Load-result selector for the data memory read path.
// Chooses one of five already-extended read values by access type and
// registers a diagnostic flag for reserved access codes.
module load_width_mux #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [2:0]    selector,
  input  logic [DW-1:0] S8,
  input  logic [DW-1:0] S16,
  input  logic [DW-1:0] W,
  input  logic [DW-1:0] U8,
  input  logic [DW-1:0] U16,
  output logic [DW-1:0] out,
  output logic          sel_err
);

  // Access-type encodings; 3, 6 and 7 are reserved.
  localparam logic [2:0] SEL_SB = 3'd0;
  localparam logic [2:0] SEL_SH = 3'd1;
  localparam logic [2:0] SEL_W  = 3'd2;
  localparam logic [2:0] SEL_UB = 3'd4;
  localparam logic [2:0] SEL_UH = 3'd5;

  logic reserved;

  // Pass the selected candidate through bit-exact; reserved codes give zero
  // so no unselected input can leak onto out.
  always_comb begin
    out      = '0;
    reserved = 1'b0;
    case (selector)
      SEL_SB:  out = S8;
      SEL_SH:  out = S16;
      SEL_W:   out = W;
      SEL_UB:  out = U8;
      SEL_UH:  out = U16;
      default: begin
        out      = '0;
        reserved = 1'b1;
      end
    endcase
  end

  // Flag reflects only the selector sampled at the last edge; cleared
  // immediately by reset. out is deliberately outside the reset domain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= reserved;
    end
  end

endmodule

// File: tb/tb_load_width_mux.sv
// Directed bench for load_width_mux: vector table plus reset and
// between-edge sequences.
module tb_load_width_mux;

  localparam int DW = 32;

  logic          CLK;
  logic          RST_N;
  logic [2:0]    selector;
  logic [DW-1:0] S8, S16, W, U8, U16;
  logic [DW-1:0] out;
  logic          sel_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [2:0]    sel;
    logic [DW-1:0] s8, s16, w, u8, u16;
    logic [DW-1:0] exp_out;
    logic          exp_err;
  } vec_t;

  vec_t vecs[$];

  load_width_mux #(.DW(DW)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .selector (selector),
    .S8       (S8),
    .S16      (S16),
    .W        (W),
    .U8       (U8),
    .U16      (U16),
    .out      (out),
    .sel_err  (sel_err)
  );

  // Clock: 10 ns period, rising edges at 5, 15, ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [DW-1:0] s8,
                       input logic [DW-1:0] s16, input logic [DW-1:0] w,
                       input logic [DW-1:0] u8, input logic [DW-1:0] u16);
    selector = sel;
    S8 = s8; S16 = s16; W = w; U8 = u8; U16 = u16;
  endtask

  task automatic add_vec(input logic [2:0] sel, input logic [DW-1:0] s8,
                         input logic [DW-1:0] s16, input logic [DW-1:0] w,
                         input logic [DW-1:0] u8, input logic [DW-1:0] u16,
                         input logic [DW-1:0] eo, input logic ee);
    vec_t v;
    v.sel = sel; v.s8 = s8; v.s16 = s16; v.w = w; v.u8 = u8; v.u16 = u16;
    v.exp_out = eo; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  initial begin
    // Vector table: inputs and hand-computed results.
    add_vec(3'd0, 32'hFFFF_FF80, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FF80, 1'b0);
    add_vec(3'd1, 32'hFFFF_FF80, 32'hFFFF_8001, 32'h1234_5678, 32'h0000_0080, 32'h0000_8001, 32'hFFFF_8001, 1'b0);
    add_vec(3'd2, 32'hFFFF_FF80, 32'hFFFF_8001, 32'h1234_5678, 32'h0000_0080, 32'h0000_8001, 32'h1234_5678, 1'b0);
    add_vec(3'd4, 32'hFFFF_FF80, 32'hFFFF_8001, 32'h1234_5678, 32'h0000_0080, 32'h0000_8001, 32'h0000_0080, 1'b0);
    add_vec(3'd5, 32'hFFFF_FF80, 32'hFFFF_8001, 32'h1234_5678, 32'h0000_0080, 32'h0000_8001, 32'h0000_8001, 1'b0);
    add_vec(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    add_vec(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    add_vec(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    add_vec(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    // Distinct value per lane so any lane swap shows up.
    for (int s = 0; s < 8; s++) begin
      logic [DW-1:0] eo;
      logic          ee;
      case (s)
        0: begin eo = 32'h0101_0101; ee = 1'b0; end
        1: begin eo = 32'h0202_0202; ee = 1'b0; end
        2: begin eo = 32'h0303_0303; ee = 1'b0; end
        4: begin eo = 32'h0404_0404; ee = 1'b0; end
        5: begin eo = 32'h0505_0505; ee = 1'b0; end
        default: begin eo = 32'h0000_0000; ee = 1'b1; end
      endcase
      add_vec(3'(s), 32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404, 32'h0505_0505, eo, ee);
    end

    // Reset state: flag low while reset held; out follows inputs anyway.
    RST_N = 1'b0;
    drive(3'd0, 32'hFFFF_FF80, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    #1;
    check("reset_sel_err", DW'(sel_err), 32'd0);
    check("reset_out", out, 32'hFFFF_FF80);
    @(posedge CLK); #1;
    check("reset_hold_sel_err", DW'(sel_err), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Table loop: drive between edges, check out combinationally, then the
    // flag after the following edge.
    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].sel, vecs[i].s8, vecs[i].s16, vecs[i].w, vecs[i].u8, vecs[i].u16);
      #1;
      check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      @(posedge CLK); #1;
      check($sformatf("vec%0d_sel_err", i), DW'(sel_err), DW'(vecs[i].exp_err));
    end

    // Reserved code clocked, then async reset between edges.
    @(negedge CLK);
    drive(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge CLK); #1;
    check("pre_reset_sel_err", DW'(sel_err), 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    check("async_reset_sel_err", DW'(sel_err), 32'd0);
    check("async_reset_out", out, 32'd0);
    @(posedge CLK); #1;
    check("reset_edge_sel_err", DW'(sel_err), 32'd0);
    @(negedge CLK);
    selector = 3'd2;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("release_sel2_sel_err", DW'(sel_err), 32'd0);
    // First edges after release sample normally.
    @(negedge CLK);
    selector = 3'd3;
    @(posedge CLK); #1;
    check("post_release_sel3_sel_err", DW'(sel_err), 32'd1);

    // Selector moves between edges: only the value at the edge counts.
    @(negedge CLK);
    selector = 3'd6;
    #1;
    check("glitch_out", out, 32'd0);
    selector = 3'd2;
    @(posedge CLK); #1;
    check("glitch_sel_err", DW'(sel_err), 32'd0);

    // W toggled between edges with selector=2: out tracks W with no clock.
    @(negedge CLK);
    selector = 3'd2;
    for (int k = 0; k < 12; k++) begin
      logic [DW-1:0] r;
      if (k % 3 == 0) @(negedge CLK);
      r = DW'($urandom_range(32'hFFFF_FFFF, 0));
      W = r;
      exp_q.push_back(r);
      #1;
      check($sformatf("w_track%0d", k), out, exp_q.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
